control_jugadas: RTL
====================

# control_jugadas

Turn and move controller for the tic-tac-toe datapath. It sits directly upstream of the board-position register bank. It converts a player's cell selection and confirm button into a one-cycle one-hot write enable for the active player, or a one-cycle illegal-move strobe. It also alternates turns and runs a per-turn countdown timer.

## Interface
- CICLOS_SEGUNDO, default 50_000_000: clock cycles per timer tick (one second).
- TIEMPO_TURNO, default 10: ticks allowed per turn; range 1–15.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- seleccion  input  4  cell index 0–8; values 9–15 are illegal.
- confirmar  input  1  confirm level, already debounced and synchronised; a move request is its rising edge.
- tablero  input  18  board feedback from the register bank, {pos8,…,pos0}; each 2-bit field is 00 empty, 01 player 1, 10 player 2.
- finJuego  input  1  game over, from the win/draw detector.
- jugador1Habilitado  output  9  one-hot write enable, player 1.
- jugador2Habilitado  output  9  one-hot write enable, player 2.
- jugadaIlegal  output  1  one-cycle illegal-move strobe.
- turno  output  1  active player: 0 is player 1, 1 is player 2.
- tiempoRestante  output  4  ticks left in the current turn.

## Operation
- Reset values:
  - state ESPERA, turno 0, both enables 0, jugadaIlegal 0.
  - tiempoRestante = TIEMPO_TURNO, prescaler 0, confirm-edge sample register 0.
- All outputs are registered.
- States:
  - ESPERA: waits for a confirm edge; the timer runs.
    - Rising edge of confirmar (current 1, previous sample 0): latch seleccion, go to VALIDA.
  - VALIDA: checks the latched index.
    - Illegal if index > 8 or the selected tablero field is not 00. Then pulse jugadaIlegal, keep turno, go to ESPERA. The timer is not reloaded.
    - Otherwise go to ESCRIBE.
  - ESCRIBE: drives bit[index] of the active player's enable high for exactly this cycle. The other player's vector stays 0. Next state CAMBIO.
  - CAMBIO: toggles turno, reloads tiempoRestante = TIEMPO_TURNO, clears the prescaler, goes to ESPERA.
  - FIN: all enables 0, jugadaIlegal 0, timer frozen; exit only by rst.
- jugadaIlegal and the enables are never both active in the same cycle.
- Timer:
  - Counts only in ESPERA.
  - The prescaler counts 0 to CICLOS_SEGUNDO−1; at its terminal count tiempoRestante decrements.
  - Timeout occurs when tiempoRestante==1 at prescaler terminal. tiempoRestante then shows 0 and the timeout action applies (see Configuration).
- Simultaneous events:
  - Confirm edge and timeout in the same cycle: confirm wins; the timer freezes on leaving ESPERA.
  - finJuego=1 in any state: FIN on the next edge. It overrides confirm and timeout.
  - An enable already asserted in ESCRIBE completes its cycle.
- Holding confirmar high generates no further requests until it falls and rises again.

## Timing
- Legal move:
  - Confirm edge sampled at edge N.
  - VALIDA during cycle N+1.
  - Enable high during cycle N+2.
  - The register bank captures at the end of N+2.
  - turno toggles and the timer reloads at the end of N+3.
- Illegal move: jugadaIlegal is high during cycle N+2 only; back in ESPERA at N+3.
- Legal move latency: 4 cycles from the sampled edge back to ESPERA.
- tablero is read in VALIDA. It is stable there because no write is pending.
- rst mid-ESCRIBE: enables drop to 0 asynchronously, and no partial turn change occurs.

## Configuration
- AUTOJUGADA_EN defined: on timeout, go to ESCRIBE using the lowest-index empty cell in tablero, then CAMBIO.
  - If no cell is empty, go to CAMBIO without writing.
- AUTOJUGADA_EN undefined: on timeout, go straight to CAMBIO. The turn is forfeited and no enable is asserted.

## Test plan
Bench parameters: CICLOS_SEGUNDO=4, TIEMPO_TURNO=3.
- Legal move: tablero all 00, turno 0, seleccion=4, confirm edge → jugador1Habilitado=9'b000010000 for one cycle, 2 cycles after the sampled edge; turno becomes 1; tiempoRestante=3.
- Illegal moves:
  - tablero pos4=01, turno 1, seleccion=4, confirm → jugadaIlegal pulses once; enables 0; turno stays 1.
  - Repeat with seleccion=9, then 15 → same response.
- Timeout with AUTOJUGADA_EN: pos0=01, pos1=10, turno 0, no confirm for 12 cycles → tiempoRestante 3→2→1→0; jugador1Habilitado=9'b000000100 one cycle; turno becomes 1.
- Timeout without the macro: same stimulus → both enables stay 0 throughout; turno toggles to 1; tiempoRestante reloads to 3.
- Game over: finJuego=1 asserted, then confirm edges with seleccion=0 → FIN; enables and jugadaIlegal stay 0; tiempoRestante frozen; rst returns turno=0, tiempoRestante=3.
- Confirm held / reset mid-operation:
  - confirmar held high 20 cycles → exactly one move.
  - rst asserted during ESCRIBE → enable drops immediately; turno=0 after release.

Source files
------------

// File: rtl/control_jugadas.sv
// control_jugadas: turn, move-validation and per-turn timer control for tic-tac-toe.
// Optional AUTOJUGADA_EN: on timeout, auto-play the lowest-index empty cell.
module control_jugadas #(
  parameter int CICLOS_SEGUNDO = 50_000_000,
  parameter int TIEMPO_TURNO   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seleccion,
  input  logic        confirmar,
  input  logic [17:0] tablero,
  input  logic        finJuego,
  output logic [8:0]  jugador1Habilitado,
  output logic [8:0]  jugador2Habilitado,
  output logic        jugadaIlegal,
  output logic        turno,
  output logic [3:0]  tiempoRestante
);

  localparam int PW = (CICLOS_SEGUNDO > 1) ? $clog2(CICLOS_SEGUNDO) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(CICLOS_SEGUNDO - 1);
  localparam logic [3:0] T_INI = 4'(TIEMPO_TURNO);

  typedef enum logic [2:0] {
    ESPERA,
    VALIDA,
    ESCRIBE,
    CAMBIO,
    FIN
  } estado_t;

  estado_t       r_estado;
  logic [3:0]    r_idx;
  logic          r_conf_prev;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_tiempo;
  logic          r_turno;
  logic          r_ilegal;
  logic [8:0]    r_en1;
  logic [8:0]    r_en2;

  logic       w_flanco;
  logic       w_tick;
  logic       w_timeout;
  logic       w_ocupado;
  logic [8:0] w_oh_sel;

  assign w_flanco  = confirmar & ~r_conf_prev;
  assign w_tick    = (r_presc == P_TERM);
  assign w_timeout = w_tick && (r_tiempo == 4'd1);
  assign w_oh_sel  = 9'd1 << r_idx;

  always_comb begin
    w_ocupado = 1'b0;
    for (int i = 0; i < 9; i++)
      if (r_idx == 4'(i))
        w_ocupado = |tablero[2*i +: 2];
  end

`ifdef AUTOJUGADA_EN
  logic       w_hay_libre;
  logic [8:0] w_oh_libre;

  // Scan downwards so the last hit is the lowest empty cell.
  always_comb begin
    w_hay_libre = 1'b0;
    w_oh_libre  = '0;
    for (int i = 8; i >= 0; i--)
      if (tablero[2*i +: 2] == 2'b00) begin
        w_hay_libre = 1'b1;
        w_oh_libre  = 9'd1 << i;
      end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= ESPERA;
      r_idx       <= '0;
      r_conf_prev <= 1'b0;
      r_presc     <= '0;
      r_tiempo    <= T_INI;
      r_turno     <= 1'b0;
      r_ilegal    <= 1'b0;
      r_en1       <= '0;
      r_en2       <= '0;
    end else begin
      r_conf_prev <= confirmar;
      r_en1       <= '0;
      r_en2       <= '0;
      r_ilegal    <= 1'b0;
      if (finJuego) begin
        r_estado <= FIN;
      end else begin
        case (r_estado)
          ESPERA: begin
            if (w_flanco) begin
              r_idx    <= seleccion;
              r_estado <= VALIDA;
            end else begin
              r_presc <= w_tick ? '0 : r_presc + 1'b1;
              if (w_tick)
                r_tiempo <= r_tiempo - 4'd1;
              if (w_timeout) begin
`ifdef AUTOJUGADA_EN
                if (w_hay_libre) begin
                  if (r_turno) r_en2 <= w_oh_libre;
                  else         r_en1 <= w_oh_libre;
                  r_estado <= ESCRIBE;
                end else begin
                  r_estado <= CAMBIO;
                end
`else
                r_estado <= CAMBIO;
`endif
              end
            end
          end
          VALIDA: begin
            if (r_idx > 4'd8 || w_ocupado) begin
              r_ilegal <= 1'b1;
              r_estado <= ESPERA;
            end else begin
              if (r_turno) r_en2 <= w_oh_sel;
              else         r_en1 <= w_oh_sel;
              r_estado <= ESCRIBE;
            end
          end
          ESCRIBE: r_estado <= CAMBIO;
          CAMBIO: begin
            r_turno  <= ~r_turno;
            r_tiempo <= T_INI;
            r_presc  <= '0;
            r_estado <= ESPERA;
          end
          FIN:     r_estado <= FIN;
          default: r_estado <= ESPERA;
        endcase
      end
    end
  end

  assign jugador1Habilitado = r_en1;
  assign jugador2Habilitado = r_en2;
  assign jugadaIlegal       = r_ilegal;
  assign turno              = r_turno;
  assign tiempoRestante     = r_tiempo;

endmodule
